// File: rtl/serial_sub4_if.sv
// rtl/serial_sub4_if.sv - start/done handshake and result bus for serial_sub4
// ovf is present only when SERIAL_SUB_OVF_EN is defined
interface serial_sub4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             borrow;
  logic [WIDTH:0]   diff;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    output start, in1, in2,
    input  busy, done, out, borrow, diff
  );

  modport slave (
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    input  start, in1, in2,
    output busy, done, out, borrow, diff
  );
endinterface

// File: rtl/serial_sub4.sv
// rtl/serial_sub4.sv - bit-serial subtractor in1 - in2, one full-subtractor step per clock, LSB first
// Defining SERIAL_SUB_OVF_EN adds the signed-overflow output ovf
module serial_sub4 #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub4_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res, out_r;
  logic             br, borrow_r;
  logic [CW-1:0]    cnt;
  logic             a0, b0, d, br_nx;
  logic             load, step, last;
  logic             busy_c, done_c;

  assign a0    = a_sh[0];
  assign b0    = b_sh[0];
  assign d     = a0 ^ b0 ^ br;
  assign br_nx = (~a0 & b0) | (~(a0 ^ b0) & br);

  assign load = (state == IDLE) && bus.start;
  assign step = (state == BUSY);
  assign last = step && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nx = BUSY;
      BUSY: begin
        busy_c = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nx = DONE;
      end
      DONE: begin
        done_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The final step's bit and borrow go straight to the outputs so DONE sees the full result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      out_r    <= '0;
      borrow_r <= 1'b0;
    end else if (load) begin
      a_sh <= bus.in1;
      b_sh <= bus.in2;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (step) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res  <= {d, res[WIDTH-1:1]};
      br   <= br_nx;
      cnt  <= cnt + CW'(1);
      if (last) begin
        out_r    <= {d, res[WIDTH-1:1]};
        borrow_r <= br_nx;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf_r <= 1'b0;
    else if (last) ovf_r <= (a0 != b0) && (d != a0);
  end

  assign bus.ovf = ovf_r;
`endif

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.out    = out_r;
  assign bus.borrow = borrow_r;
  assign bus.diff   = {borrow_r, out_r};

endmodule
